// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding, coin unit values, default price.
// Quarter acceptance is controlled by the VEND_QUARTER_EN macro (see vend_coin_decode).
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_e;

    localparam int unsigned PRICE_DEFAULT = 32'd3;

    localparam logic [2:0] NICKEL_UNITS  = 3'd1;
    localparam logic [2:0] DIME_UNITS    = 3'd2;
    localparam logic [2:0] QUARTER_UNITS = 3'd5;

    // Number of coin strobes raised in the same cycle.
    function automatic logic [1:0] coin_count(input logic n, input logic d, input logic q);
        return {1'b0, n} + {1'b0, d} + {1'b0, q};
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: flags any coin activity, whether it is creditable, and its unit value.
// Macro VEND_QUARTER_EN: defined -> quarters are worth 5 units; undefined -> quarters are always rejected.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    output logic       present,
    output logic       valid,
    output logic [2:0] units
);

    logic       quarter_ok_s;
    logic [1:0] count_s;

`ifdef VEND_QUARTER_EN
    assign quarter_ok_s = 1'b1;
`else
    assign quarter_ok_s = 1'b0;
`endif

    // Exactly one accepted coin is creditable; anything else is returned.
    always_comb begin
        count_s = coin_count(nickel, dime, quarter);
        present = (count_s != 2'd0);
        valid   = (count_s == 2'd1) && (quarter_ok_s || !quarter);
        case ({nickel, dime, quarter})
            3'b100:  units = NICKEL_UNITS;
            3'b010:  units = DIME_UNITS;
            3'b001:  units = QUARTER_UNITS;
            default: units = 3'd0;
        endcase
    end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: accumulates credit, vends at PRICE, pays change one nickel per cycle.
// Macro VEND_QUARTER_EN enables quarter acceptance (default build rejects quarters).
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE = PRICE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       cancel,
    output logic       dispense,
    output logic       change_nickel,
    output logic       coin_reject,
    output logic [3:0] credit,
    output logic       busy
);

    localparam logic [4:0] PRICE_W5 = 5'(PRICE);
    localparam logic [3:0] PRICE_W4 = 4'(PRICE);

    vend_state_e state_r;
    vend_state_e next_state_s;
    logic [3:0]  credit_r;
    logic [3:0]  credit_nxt_s;
    logic        dispense_r;
    logic        change_r;
    logic        reject_r;
    logic        busy_r;
    logic        dispense_nxt_s;
    logic        change_nxt_s;
    logic        reject_nxt_s;
    logic        busy_nxt_s;
    logic        coin_present_s;
    logic        coin_valid_s;
    logic [2:0]  coin_units_s;
    logic [4:0]  sum_s;
    logic [3:0]  over_s;

    vend_coin_decode u_decode (
        .nickel  (nickel),
        .dime    (dime),
        .quarter (quarter),
        .present (coin_present_s),
        .valid   (coin_valid_s),
        .units   (coin_units_s)
    );

    // Sum never exceeds PRICE+4 (<= 14), so the 4-bit difference is exact whenever sum >= PRICE.
    assign sum_s  = {1'b0, credit_r} + {2'b00, coin_units_s};
    assign over_s = sum_s[3:0] - PRICE_W4;

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            credit_r   <= 4'd0;
            dispense_r <= 1'b0;
            change_r   <= 1'b0;
            reject_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            credit_r   <= credit_nxt_s;
            dispense_r <= dispense_nxt_s;
            change_r   <= change_nxt_s;
            reject_r   <= reject_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Next state and credit; a coin in the same cycle takes precedence over cancel.
    always_comb begin
        next_state_s = state_r;
        credit_nxt_s = credit_r;
        case (state_r)
            ST_IDLE, ST_ACCUM: begin
                if (coin_present_s) begin
                    if (!coin_valid_s) begin
                        next_state_s = state_r;
                        credit_nxt_s = credit_r;
                    end else if (sum_s >= PRICE_W5) begin
                        next_state_s = ST_DISPENSE;
                        credit_nxt_s = over_s;
                    end else begin
                        next_state_s = ST_ACCUM;
                        credit_nxt_s = sum_s[3:0];
                    end
                end else if (cancel && (state_r == ST_ACCUM) && (credit_r != 4'd0)) begin
                    next_state_s = ST_CHANGE;
                    credit_nxt_s = credit_r - 4'd1;
                end else begin
                    next_state_s = state_r;
                    credit_nxt_s = credit_r;
                end
            end
            ST_DISPENSE, ST_CHANGE: begin
                if (credit_r != 4'd0) begin
                    next_state_s = ST_CHANGE;
                    credit_nxt_s = credit_r - 4'd1;
                end else begin
                    next_state_s = ST_IDLE;
                    credit_nxt_s = 4'd0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                credit_nxt_s = 4'd0;
            end
        endcase
    end

    // Output decode: DISPENSE is entered only on a vend, CHANGE only on a nickel payout.
    always_comb begin
        dispense_nxt_s = 1'b0;
        change_nxt_s   = 1'b0;
        busy_nxt_s     = 1'b0;
        reject_nxt_s   = 1'b0;
        case (next_state_s)
            ST_DISPENSE: begin
                dispense_nxt_s = 1'b1;
                busy_nxt_s     = 1'b1;
            end
            ST_CHANGE: begin
                change_nxt_s = 1'b1;
                busy_nxt_s   = 1'b1;
            end
            default: begin
                dispense_nxt_s = 1'b0;
                change_nxt_s   = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
        if ((state_r == ST_DISPENSE) || (state_r == ST_CHANGE)) begin
            reject_nxt_s = coin_present_s;
        end else begin
            reject_nxt_s = coin_present_s && !coin_valid_s;
        end
    end

    assign dispense      = dispense_r;
    assign change_nickel = change_r;
    assign coin_reject   = reject_r;
    assign credit        = credit_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: per-cycle reference-model scoreboard plus directed scenarios.
// Covers both VEND_QUARTER_EN builds.
module tb_vend_sequencer;

    localparam int PRICE = 3;
`ifdef VEND_QUARTER_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct packed {
        logic       d;
        logic       c;
        logic       r;
        logic       b;
        logic [3:0] cr;
    } exp_t;

    bit         clk;
    logic       reset   = 1'b1;
    logic       nickel  = 1'b0;
    logic       dime    = 1'b0;
    logic       quarter = 1'b0;
    logic       cancel  = 1'b0;
    logic       dispense;
    logic       change_nickel;
    logic       coin_reject;
    logic       busy;
    logic [3:0] credit;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_state = 0;
    int   m_credit = 0;
    logic [7:0] want;

    vend_sequencer #(.PRICE(PRICE)) dut (
        .clk           (clk),
        .reset         (reset),
        .nickel        (nickel),
        .dime          (dime),
        .quarter       (quarter),
        .cancel        (cancel),
        .dispense      (dispense),
        .change_nickel (change_nickel),
        .coin_reject   (coin_reject),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {dispense, change_nickel, coin_reject, busy, credit};
    endfunction

    // Reference model: 0=IDLE 1=ACCUM 2=DISPENSE 3=CHANGE; computes outputs after the coming edge.
    task automatic model_step();
        exp_t e;
        int   n;
        int   val;
        bit   bad;
        e = '0;
        if (reset) begin
            m_state  = 0;
            m_credit = 0;
        end else begin
            n   = int'(nickel) + int'(dime) + int'(quarter);
            bad = (n > 1) || (quarter && !QEN);
            val = nickel ? 1 : (dime ? 2 : 5);
            if (m_state <= 1) begin
                if (n > 0) begin
                    if (bad) begin
                        e.r = 1'b1;
                    end else if (m_credit + val >= PRICE) begin
                        m_state  = 2;
                        m_credit = m_credit + val - PRICE;
                        e.d      = 1'b1;
                    end else begin
                        m_state  = 1;
                        m_credit = m_credit + val;
                    end
                end else if (cancel && m_state == 1 && m_credit > 0) begin
                    m_state  = 3;
                    m_credit = m_credit - 1;
                    e.c      = 1'b1;
                end
            end else begin
                e.r = (n > 0);
                if (m_credit > 0) begin
                    m_state  = 3;
                    m_credit = m_credit - 1;
                    e.c      = 1'b1;
                end else begin
                    m_state = 0;
                end
            end
        end
        e.b  = (m_state >= 2);
        e.cr = 4'(m_credit);
        sb_q.push_back(e);
    endtask

    task automatic pulse(input logic n, input logic d, input logic q, input logic c);
        nickel  = n;
        dime    = d;
        quarter = q;
        cancel  = c;
        model_step();
        @(posedge clk);
        #1;
        nickel  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;
        cancel  = 1'b0;
    endtask

    // Scoreboard monitor: one expected entry per clock edge, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (outs() !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got d/c/r/b/credit=%b want %b", $time, outs(), e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        want = 8'b0000_0000;
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL reset_state got %b want %b", outs(), want); end
        reset = 1'b0;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dime_nickel();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        want = {4'b0000, 4'd2};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL dime_credit got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        want = {4'b1001, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL dime_nickel_vend got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL vend_no_change got %b want %b", outs(), want); end
    endtask

    task automatic test_multi_coin();
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        want = {4'b0010, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL multi_coin_reject got %b want %b", outs(), want); end
        pulse(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL nickel_quarter_reject got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL reject_one_cycle got %b want %b", outs(), want); end
    endtask

    task automatic test_cancel();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        want = {4'b0101, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL cancel_change got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL cancel_idle got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL cancel_in_idle got %b want %b", outs(), want); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        want = {4'b0101, 4'd1};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL cancel_dime got %b want %b", outs(), want); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        want = {4'b0111, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL coin_in_change got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        want = {4'b0000, 4'd2};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL coin_over_cancel got %b want %b", outs(), want); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        want = {4'b1001, 4'd1};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL overpay_vend got %b want %b", outs(), want); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        want = {4'b0111, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL coin_in_dispense got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL back_to_idle got %b want %b", outs(), want); end
    endtask

    task automatic test_quarter();
`ifdef VEND_QUARTER_EN
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        want = {4'b1001, 4'd2};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_vend got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0101, 4'd1};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_change1 got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0101, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_change2 got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_done got %b want %b", outs(), want); end
`else
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        want = {4'b0010, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_reject got %b want %b", outs(), want); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        want = {4'b0010, 4'd1};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_reject_accum got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL quarter_cleanup got %b want %b", outs(), want); end
`endif
    endtask

    task automatic test_reset_mid_change();
`ifdef VEND_QUARTER_EN
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        want = {4'b0101, 4'd3};
`else
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        want = {4'b0101, 4'd1};
`endif
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL pre_reset_change got %b want %b", outs(), want); end
        reset = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        want = {4'b0000, 4'd0};
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL reset_mid_change got %b want %b", outs(), want); end
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs() !== want) begin errors++; $display("FAIL change_discarded got %b want %b", outs(), want); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            reset = (r == 19);
            case (r)
                0, 1, 2:  pulse(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                3, 4:     pulse(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
                5:        pulse(1'b0, 1'b0, 1'b1, 1'b0);
                6:        pulse(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                7, 8, 9:  pulse(1'b0, 1'b0, 1'b0, 1'b1);
                default:  pulse(1'b0, 1'b0, 1'b0, 1'b0);
            endcase
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dime_nickel();
        test_multi_coin();
        test_cancel();
        test_back_to_back();
        test_quarter();
        test_reset_mid_change();
        test_random();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
